// File: rtl/vector_accumulate_unit.sv
// rtl/vector_accumulate_unit.sv - per-chain lane-wise vector pass/sum/max accumulator
// Each chain either forwards vectors or folds them until eof, then emits one result.
module vector_accumulate_unit #(
  parameter int                        N                       = 8,
  parameter int                        DATA_WIDTH              = 32,
  parameter int                        MAX_CHAINS              = 4,
  parameter logic [7:0]                PERSONAL_CONFIG_ID      = 8'd0,
  parameter int                        CNT_WIDTH               = 16,
  parameter logic [8*MAX_CHAINS-1:0]   INITIAL_FIRMWARE_ACC_OP = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tracing,
  input  logic                          valid_in,
  input  logic                          eof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
  input  logic [7:0]                    configId,
  input  logic [7:0]                    configData,
  input  logic [N*DATA_WIDTH-1:0]       vector_in,
  output logic [N*DATA_WIDTH-1:0]       vector_out,
  output logic [CNT_WIDTH-1:0]          count_out,
  output logic [$clog2(MAX_CHAINS)-1:0] chainId_out,
  output logic                          valid_out,
  output logic                          eof_out
);

  localparam int CW = $clog2(MAX_CHAINS);
  localparam int VW = N * DATA_WIDTH;
  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_SUM  = 2'd1;
  localparam logic [1:0] OP_MAX  = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  logic [1:0]           fw_op  [MAX_CHAINS];
  logic [VW-1:0]        acc    [MAX_CHAINS];
  logic [CNT_WIDTH-1:0] cnt    [MAX_CHAINS];
  logic [MAX_CHAINS-1:0] active;

  logic                 accept;
  logic [1:0]           cur_op;
  logic                 is_pass;
  logic [CW-1:0]        cfg_chain;
  logic                 cfg_write;
  logic [VW-1:0]        folded;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 unused_cfg;

  assign accept     = valid_in & tracing;
  assign cur_op     = fw_op[chainId_in];
  assign is_pass    = (cur_op == OP_PASS) || (cur_op == OP_RSVD);
  assign cfg_chain  = configData[2 +: CW];
  assign cfg_write  = (configId == PERSONAL_CONFIG_ID);
  assign unused_cfg = ^configData[7:2+CW];

  // Fold the incoming vector into the addressed chain; a fresh frame starts from the input.
  always_comb begin
    folded   = vector_in;
    cnt_next = CNT_WIDTH'(1);
    if (active[chainId_in]) begin
      cnt_next = (&cnt[chainId_in]) ? cnt[chainId_in] : cnt[chainId_in] + 1'b1;
      for (int l = 0; l < N; l++) begin
        if (cur_op == OP_SUM) begin
          folded[l*DATA_WIDTH +: DATA_WIDTH] = acc[chainId_in][l*DATA_WIDTH +: DATA_WIDTH]
                                             + vector_in[l*DATA_WIDTH +: DATA_WIDTH];
        end else if ($signed(acc[chainId_in][l*DATA_WIDTH +: DATA_WIDTH]) >
                     $signed(vector_in[l*DATA_WIDTH +: DATA_WIDTH])) begin
          folded[l*DATA_WIDTH +: DATA_WIDTH] = acc[chainId_in][l*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vector_out  <= '0;
      count_out   <= '0;
      chainId_out <= '0;
      valid_out   <= 1'b0;
      eof_out     <= 1'b0;
      active      <= '0;
      for (int c = 0; c < MAX_CHAINS; c++) begin
        fw_op[c] <= INITIAL_FIRMWARE_ACC_OP[c*8 +: 2];
        acc[c]   <= '0;
        cnt[c]   <= '0;
      end
    end else begin
      // Config is accepted even while tracing is frozen.
      if (cfg_write) begin
        fw_op[cfg_chain] <= configData[1:0];
      end
      valid_out <= 1'b0;
      eof_out   <= 1'b0;
      if (accept) begin
        if (is_pass) begin
          vector_out  <= vector_in;
          count_out   <= CNT_WIDTH'(1);
          chainId_out <= chainId_in;
          eof_out     <= eof_in;
          valid_out   <= 1'b1;
        end else if (eof_in) begin
          vector_out          <= folded;
          count_out           <= cnt_next;
          chainId_out         <= chainId_in;
          eof_out             <= 1'b1;
          valid_out           <= 1'b1;
          acc[chainId_in]     <= '0;
          cnt[chainId_in]     <= '0;
          active[chainId_in]  <= 1'b0;
        end else begin
          acc[chainId_in]     <= folded;
          cnt[chainId_in]     <= cnt_next;
          active[chainId_in]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_accumulate_unit.sv
// tb/tb_vector_accumulate_unit.sv - self-checking bench for vector_accumulate_unit
module tb_vector_accumulate_unit;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int NC = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tracing;
  logic             valid_in;
  logic             eof_in;
  logic [1:0]       chainId_in;
  logic [7:0]       configId;
  logic [7:0]       configData;
  logic [N*DW-1:0]  vector_in;
  logic [N*DW-1:0]  vector_out;
  logic [15:0]      count_out;
  logic [1:0]       chainId_out;
  logic             valid_out;
  logic             eof_out;

  int tests = 0;
  int fails = 0;

  vector_accumulate_unit dut (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in),
    .chainId_in(chainId_in), .configId(configId), .configData(configData),
    .vector_in(vector_in), .vector_out(vector_out), .count_out(count_out),
    .chainId_out(chainId_out), .valid_out(valid_out), .eof_out(eof_out)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer lanes per chain, frame state as flags.
  int              m_op  [NC];
  int              m_acc [NC][N];
  int              m_cnt [NC];
  bit              m_act [NC];
  logic [N*DW-1:0] e_vec;
  int              e_cnt;
  int              e_chain;
  bit              e_valid;
  bit              e_eof;

  function automatic logic [N*DW-1:0] splat(input int x);
    logic [N*DW-1:0] v;
    for (int l = 0; l < N; l++) v[l*DW +: DW] = x;
    return v;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_op[c] = 0; m_cnt[c] = 0; m_act[c] = 0;
      for (int l = 0; l < N; l++) m_acc[c][l] = 0;
    end
    e_vec = '0; e_cnt = 0; e_chain = 0; e_valid = 0; e_eof = 0;
  endfunction

  function automatic void model_cycle(input bit v, input bit e, input int ch,
                                      input logic [N*DW-1:0] vec, input bit tr,
                                      input logic [7:0] cid, input logic [7:0] cdat);
    int x;
    e_valid = 0;
    e_eof   = 0;
    if (v && tr) begin
      if (m_op[ch] == 1 || m_op[ch] == 2) begin
        for (int l = 0; l < N; l++) begin
          x = vec[l*DW +: DW];
          if (!m_act[ch])        m_acc[ch][l] = x;
          else if (m_op[ch] == 1) m_acc[ch][l] = m_acc[ch][l] + x;
          else if (x > m_acc[ch][l]) m_acc[ch][l] = x;
        end
        m_cnt[ch] = m_act[ch] ? ((m_cnt[ch] < 65535) ? m_cnt[ch] + 1 : 65535) : 1;
        m_act[ch] = 1;
        if (e) begin
          for (int l = 0; l < N; l++) e_vec[l*DW +: DW] = m_acc[ch][l];
          e_cnt = m_cnt[ch]; e_chain = ch; e_valid = 1; e_eof = 1;
          m_act[ch] = 0; m_cnt[ch] = 0;
          for (int l = 0; l < N; l++) m_acc[ch][l] = 0;
        end
      end else begin
        e_vec = vec; e_cnt = 1; e_chain = ch; e_valid = 1; e_eof = e;
      end
    end
    if (cid == 8'd0) m_op[cdat[3:2]] = cdat[1:0];
  endfunction

  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid_out", valid_out, e_valid);
    chk("vector_out", vector_out, e_vec);
    chk("count_out", count_out, e_cnt);
    chk("chainId_out", chainId_out, e_chain);
    if (e_valid) chk("eof_out", eof_out, e_eof);
  endtask

  task automatic step(input bit v, input bit e, input int ch, input logic [N*DW-1:0] vec,
                      input bit tr = 1'b1, input logic [7:0] cid = 8'hFF,
                      input logic [7:0] cdat = 8'h00);
    @(negedge clk);
    valid_in = v; eof_in = e; chainId_in = 2'(ch); vector_in = vec;
    tracing = tr; configId = cid; configData = cdat;
    @(posedge clk);
    model_cycle(v, e, ch, vec, tr, cid, cdat);
    #1;
    check_all();
  endtask

  task automatic cfg(input logic [7:0] cdat);
    step(1'b0, 1'b0, 0, '0, 1'b1, 8'd0, cdat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid_in = 0; eof_in = 0; configId = 8'hFF; rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("eof_out_reset", eof_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N*DW-1:0] v;
    logic [N*DW-1:0] want;
    rst_n = 1'b1; tracing = 1'b1; valid_in = 0; eof_in = 0; chainId_in = 0;
    configId = 8'hFF; configData = 0; vector_in = '0;
    model_reset();
    do_reset();

    // PASS on chain 0, lanes 1..8
    for (int l = 0; l < N; l++) v[l*DW +: DW] = l + 1;
    step(1, 0, 0, v);
    chk("pass_vec", vector_out, v);
    chk("pass_cnt", count_out, 16'd1);

    // SUM on chain 1: 10+20+30
    cfg(8'h05);
    step(1, 0, 1, splat(10));
    step(1, 0, 1, splat(20));
    step(1, 1, 1, splat(30));
    chk("sum60", vector_out, splat(60));
    chk("sum_cnt3", count_out, 16'd3);

    // MAX on chain 2: lane0 -5, 7, -100 -> 7; then single -3
    cfg(8'h0A);
    v = '0; v[DW-1:0] = -5;   step(1, 0, 2, v);
    v = '0; v[DW-1:0] = 7;    step(1, 0, 2, v);
    v = '0; v[DW-1:0] = -100; step(1, 1, 2, v);
    chk("max_lane0", vector_out[DW-1:0], 32'd7);
    v = '0; v[DW-1:0] = -3;   step(1, 1, 2, v);
    chk("max_single", vector_out[DW-1:0], 32'hFFFF_FFFD);
    chk("max_single_cnt", count_out, 16'd1);

    // Interleave chain1 SUM / chain2 MAX, eof on the last two cycles
    for (int i = 0; i < 4; i++) begin
      step(1, i == 3, 1, splat(i + 1));
      step(1, i == 3, 2, splat(5 - 2 * i));
      if (i == 3) chk("ilv_max", vector_out, splat(5));
    end

    // SUM wrap
    step(1, 0, 1, splat(-1));
    step(1, 1, 1, splat(2));
    chk("sum_wrap", vector_out, splat(1));

    // Reset mid-frame discards partial sums and restores PASS ops
    step(1, 0, 1, splat(100));
    step(1, 0, 1, splat(200));
    do_reset();
    cfg(8'h05);
    step(1, 1, 1, splat(4));
    chk("post_reset_sum", vector_out, splat(4));
    chk("post_reset_cnt", count_out, 16'd1);

    // tracing=0 freezes the frame; it resumes afterward
    step(1, 0, 1, splat(3));
    step(1, 0, 1, splat(50), 1'b0);
    step(1, 1, 1, splat(70), 1'b0);
    chk("frozen_valid", valid_out, 1'b0);
    step(1, 1, 1, splat(6));
    want = splat(9);
    chk("resume_sum", vector_out, want);
    chk("resume_cnt", count_out, 16'd2);

    // Randomized traffic with occasional reconfiguration and freezes
    for (int i = 0; i < 400; i++) begin
      for (int l = 0; l < N; l++)
        v[l*DW +: DW] = ($urandom % 3 == 0) ? 32'($urandom % 16) - 8 : $urandom;
      step($urandom % 4 != 0, $urandom % 5 == 0, int'($urandom % NC), v,
           $urandom % 8 != 0, ($urandom % 10 == 0) ? 8'd0 : 8'h33, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
